// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store path.
// Access-size encoding, queue entry layout, lane mask helper.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        LS_W = 2'b00,
        LS_H = 2'b01,
        LS_B = 2'b10,
        LS_D = 2'b11
    } ls_op_e;

    localparam int SB_AW = 64;
    localparam int SB_DW = 64;
    localparam int SB_LN = 8;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
        logic [SB_LN-1:0] byteen;
    } sb_entry_t;

    function automatic logic [7:0] lane_mask(
        input logic [1:0] ls_op,
        input logic [2:0] off,
        input int         lanes
    );
        logic [7:0] base;
        logic [7:0] lim;
        case (ls_op)
            LS_B:    base = 8'h01;
            LS_H:    base = 8'h03;
            LS_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        lim = 8'hFF >> (8 - lanes);
        return (base << off) & lim;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Size/offset to byte-enables, lane-positioned data and misalignment.
// Purely combinational; shared by the store and load paths.
module lane_align
    import store_buffer_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(LANES)
) (
    input  logic [1:0]        ls_op,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    output logic [LANES-1:0]  byteen,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [2:0]        off3;
    logic [7:0]        mask;
    logic [DATA_W-1:0] shifted;
    logic              unused_mask;

    always_comb begin
        off3    = 3'(off);
        mask    = lane_mask(ls_op, off3, LANES);
        byteen  = mask[LANES-1:0];
        shifted = wdata << {off, 3'b000};
        data    = '0;
        for (int i = 0; i < LANES; i++) begin
            data[8*i +: 8] = byteen[i] ? shifted[8*i +: 8] : 8'h00;
        end
        // A double store cannot fit on a 32-bit bus at all.
        case (ls_op)
            LS_B:    misaligned = 1'b0;
            LS_H:    misaligned = off3[0];
            LS_W:    misaligned = (off3[1:0] != 2'b00);
            default: misaligned = (DATA_W == 32) || (off3 != 3'd0);
        endcase
    end

    assign unused_mask = ^mask;

endmodule

// File: rtl/store_buffer.sv
// Store queue between MEM-stage store logic and the data-memory bus.
// Aligns stores, traps misaligned ones, drains in FIFO order.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int LANES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(LANES),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_ls_op,
    output logic              req_exc,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [LANES-1:0]  mem_byteen,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_hit,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    sb_entry_t         mem_q [DEPTH];
    sb_entry_t         mem_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [LANES-1:0]  la_byteen;
    logic [DATA_W-1:0] la_data;
    logic              la_mis;
    logic              push, pop;
    sb_entry_t         new_entry, head;
    logic [SB_AW-1:0]  chk_al;
    logic              unused_head;

    lane_align #(.DATA_W(DATA_W)) u_align (
        .ls_op      (req_ls_op),
        .off        (req_addr[OFF_W-1:0]),
        .wdata      (req_wdata),
        .byteen     (la_byteen),
        .data       (la_data),
        .misaligned (la_mis)
    );

    assign head        = mem_q[rd_q];
    assign mem_valid   = valid_q[rd_q];
    assign mem_addr    = head.addr[ADDR_W-1:0];
    assign mem_wdata   = head.data[DATA_W-1:0];
    assign mem_byteen  = head.byteen[LANES-1:0];
    assign unused_head = ^{head.addr, head.data, head.byteen};
    assign count       = cnt_q;
    assign full        = (cnt_q == CNT_W'(DEPTH));
    assign empty       = (cnt_q == '0);

    // mem_ready -> req_ready is deliberate: a full queue accepts on a pop.
    assign pop       = mem_valid & mem_ready;
    assign req_ready = !full | pop;
    assign req_exc   = req_valid & la_mis;
    assign push      = req_valid & req_ready & !la_mis;

    always_comb begin
        new_entry.addr   = SB_AW'({req_addr[ADDR_W-1:OFF_W], OFF_W'(0)});
        new_entry.data   = SB_DW'(la_data);
        new_entry.byteen = SB_LN'(la_byteen);
        chk_al = SB_AW'({chk_addr[ADDR_W-1:OFF_W], OFF_W'(0)});
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && mem_q[i].addr == chk_al) chk_hit = 1'b1;
        end
    end

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (pop) begin
            valid_d[rd_q] = 1'b0;
            rd_d          = rd_q + 1'b1;
        end
        if (push) begin
            mem_d[wr_q]   = new_entry;
            valid_d[wr_q] = 1'b1;
            wr_d          = wr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer on 32- and 64-bit buses.
// Expected drain entries are queued at drive time and popped on each pop.
module tb_store_buffer;
    import store_buffer_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_exc;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_ls_op;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] chk_addr;
    logic        chk_hit, full, empty;
    logic [2:0]  count;

    logic        w_req_valid, w_req_ready, w_req_exc;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic [1:0]  w_req_ls_op;
    logic        w_mem_valid, w_mem_ready;
    logic [31:0] w_mem_addr;
    logic [63:0] w_mem_wdata;
    logic [7:0]  w_mem_byteen;
    logic [31:0] w_chk_addr;
    logic        w_chk_hit, w_full, w_empty;
    logic [2:0]  w_count;

    always #5 clk = ~clk;

    store_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ls_op(req_ls_op), .req_exc(req_exc),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen),
        .chk_addr(chk_addr), .chk_hit(chk_hit),
        .count(count), .full(full), .empty(empty)
    );

    store_buffer #(.ADDR_W(32), .DATA_W(64), .DEPTH(4)) dut64 (
        .clk(clk), .reset(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .req_ls_op(w_req_ls_op), .req_exc(w_req_exc),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_byteen(w_mem_byteen),
        .chk_addr(w_chk_addr), .chk_hit(w_chk_hit),
        .count(w_count), .full(w_full), .empty(w_empty)
    );

    function automatic bit mis32(input logic [1:0] op, input logic [31:0] a);
        case (op)
            LS_B:    return 1'b0;
            LS_H:    return a[0];
            LS_W:    return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t model32(input logic [31:0] a,
                                     input logic [31:0] d,
                                     input logic [1:0] op);
        exp_t e;
        logic [3:0] base;
        int off = int'(a[1:0]);
        case (op)
            LS_B:    base = 4'h1;
            LS_H:    base = 4'h3;
            default: base = 4'hF;
        endcase
        e.be   = 4'(base << off);
        e.addr = {a[31:2], 2'b00};
        e.data = '0;
        for (int i = 0; i < 4; i++)
            if (e.be[i]) e.data[8*i +: 8] = d[8*(i-off) +: 8];
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mem_valid && mem_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pop addr=%h", mem_addr);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data ||
                    mem_byteen !== e.be) begin
                    failures++;
                    $display("FAIL drain got a=%h d=%h be=%b exp a=%h d=%h be=%b",
                             mem_addr, mem_wdata, mem_byteen,
                             e.addr, e.data, e.be);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] op, input bit accept);
        bit bad = mis32(op, a);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_ls_op = op;
        #1;
        checks++;
        if (req_exc !== bad) begin
            failures++;
            $display("FAIL req_exc a=%h got=%b exp=%b", a, req_exc, bad);
        end
        if (!bad && accept) sb.push_back(model32(a, d, op));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 20 && count != 0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (count !== 3'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL drain_done count=%0d left=%0d exp 0", count, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
            mem_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset cnt=%0d e=%b f=%b mv=%b rr=%b exp 0 1 0 0 1",
                     count, empty, full, mem_valid, req_ready);
        end
        checks++;
        if (w_count !== 3'd0 || w_empty !== 1'b1 || w_mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset64 cnt=%0d e=%b mv=%b exp 0 1 0",
                     w_count, w_empty, w_mem_valid);
        end
    endtask

    task automatic test_byte_lane();
        mem_ready = 1'b1;
        send(32'h1003, 32'h0000_00AB, LS_B, 1);
        checks++;
        if (mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL byte_visible mv=%b exp 1", mem_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (count !== 3'd0 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL byte_drained cnt=%0d mv=%b exp 0 0", count, mem_valid);
        end
    endtask

    task automatic test_misaligned();
        mem_ready = 1'b1;
        send(32'h2001, 32'h1234, LS_H, 1);
        checks++;
        if (count !== 3'd0 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL mis_h_queued cnt=%0d mv=%b exp 0 0", count, mem_valid);
        end
        send(32'h2002, 32'h5678, LS_W, 1);
        send(32'h2000, 32'h9ABC, LS_D, 1);
        send(32'h2002, 32'hFFFF_BEEF, LS_H, 1);
        drain_wait();
    endtask

    task automatic test_full();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'h3000 + 32'(4*i), 32'hA000_0000 + 32'(i), LS_W, 1);
        checks++;
        if (full !== 1'b1 || req_ready !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL full f=%b rr=%b cnt=%0d exp 1 0 4", full, req_ready, count);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_ready rr=%b exp 1", req_ready);
        end
        send(32'h3010, 32'h0000_00B5, LS_W, 1);
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL full_swap cnt=%0d exp 4", count);
        end
        drain_wait();
    endtask

    task automatic test_chk();
        mem_ready = 1'b0;
        send(32'h1000, 32'h55, LS_W, 1);
        chk_addr = 32'h1002;
        #1;
        checks++;
        if (chk_hit !== 1'b1) begin
            failures++;
            $display("FAIL chk_same_word hit=%b exp 1", chk_hit);
        end
        chk_addr = 32'h1004;
        #1;
        checks++;
        if (chk_hit !== 1'b0) begin
            failures++;
            $display("FAIL chk_other_word hit=%b exp 0", chk_hit);
        end
        req_valid = 1'b1;
        req_addr  = 32'h5000;
        req_wdata = 32'h66;
        req_ls_op = LS_W;
        chk_addr  = 32'h5001;
        #1;
        checks++;
        if (chk_hit !== 1'b0) begin
            failures++;
            $display("FAIL chk_push_excluded hit=%b exp 0", chk_hit);
        end
        sb.push_back(model32(32'h5000, 32'h66, LS_W));
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (chk_hit !== 1'b1) begin
            failures++;
            $display("FAIL chk_after_push hit=%b exp 1", chk_hit);
        end
        chk_addr  = 32'h1002;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (chk_hit !== 1'b1) begin
            failures++;
            $display("FAIL chk_popping hit=%b exp 1", chk_hit);
        end
        @(posedge clk); #1;
        checks++;
        if (chk_hit !== 1'b0) begin
            failures++;
            $display("FAIL chk_after_pop hit=%b exp 0", chk_hit);
        end
        drain_wait();
    endtask

    task automatic test_reset_flush();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'h4000 + 32'(4*i), 32'hC0DE_0000 + 32'(i), LS_W, 1);
        checks++;
        if (count !== 3'd3 || mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre cnt=%0d mv=%b exp 3 1", count, mem_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        checks++;
        if (mem_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL flush mv=%b cnt=%0d e=%b exp 0 0 1", mem_valid, count, empty);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_reoffer cyc=%0d mv=%b exp 0", i, mem_valid);
            end
        end
    endtask

    task automatic w_send(input logic [31:0] a, input logic [63:0] d,
                          input logic [1:0] op, input bit x_exc,
                          input logic [7:0] x_be, input logic [63:0] x_data);
        w_req_valid = 1'b1;
        w_req_addr  = a;
        w_req_wdata = d;
        w_req_ls_op = op;
        #1;
        checks++;
        if (w_req_exc !== x_exc) begin
            failures++;
            $display("FAIL w_exc a=%h got=%b exp=%b", a, w_req_exc, x_exc);
        end
        @(posedge clk); #1;
        w_req_valid = 1'b0;
        checks++;
        if (x_exc) begin
            if (w_mem_valid !== 1'b0) begin
                failures++;
                $display("FAIL w_exc_queued mv=%b exp 0", w_mem_valid);
            end
        end else if (w_mem_valid !== 1'b1 || w_mem_byteen !== x_be ||
                     w_mem_wdata !== x_data ||
                     w_mem_addr !== {a[31:3], 3'b000}) begin
            failures++;
            $display("FAIL w_head a=%h mv=%b be=%h d=%h got, exp be=%h d=%h",
                     w_mem_addr, w_mem_valid, w_mem_byteen, w_mem_wdata,
                     x_be, x_data);
        end
    endtask

    task automatic test_dw64();
        w_mem_ready = 1'b1;
        w_send(32'h8, 64'h0102_0304_0506_0708, LS_D, 0,
               8'hFF, 64'h0102_0304_0506_0708);
        w_send(32'hC, 64'h1122_3344, LS_W, 0,
               8'hF0, 64'h1122_3344_0000_0000);
        w_send(32'h4, 64'h1, LS_D, 1, 8'h00, 64'h0);
        w_send(32'h6, 64'hFFFF_FFFF_FFFF_ABCD, LS_H, 0,
               8'hC0, 64'hABCD_0000_0000_0000);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_ls_op = LS_W; mem_ready = 1'b0; chk_addr = '0;
        w_req_valid = 1'b0; w_req_addr = '0; w_req_wdata = '0;
        w_req_ls_op = LS_W; w_mem_ready = 1'b0; w_chk_addr = '0;
        test_reset();
        test_byte_lane();
        test_misaligned();
        test_full();
        test_chk();
        test_reset_flush();
        test_dw64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
